// File: rtl/seg_scan4_pkg.sv
// Shared constants for the four-digit multiplexed seven-segment scanner:
// glyph table, segment bit positions and the default scan divider.
package seg_scan4_pkg;

  localparam int SCAN_DIV_DEFAULT = 100000;

  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_idx_e;

  localparam int SEG_W = int'(SEG_G) + 1;

  localparam logic [SEG_W-1:0] SEG_OFF  = '1;
  localparam logic [3:0]       SUB_LAST = 4'd15;
  localparam logic [1:0]       DIG_LAST = 2'd3;

  // Active-low patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [SEG_W-1:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nib);
    return HEX_GLYPH[nib];
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7_decode
  import seg_scan4_pkg::*;
(
  input  logic [3:0]       hex_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = hex_glyph(hex_i);
  end

endmodule

// File: rtl/seg_scan4.sv
// Four-digit multiplexed seven-segment driver with per-frame shadowed digit
// codes, PWM brightness per digit slot and registered active-low outputs.
module seg_scan4
  import seg_scan4_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic [7:0]       d0,
  input  logic [7:0]       d1,
  input  logic [7:0]       d2,
  input  logic [7:0]       d3,
  input  logic [3:0]       raw,
  input  logic [3:0]       dp_in,
  input  logic             blank,
  input  logic [3:0]       duty,
  output logic [SEG_W-1:0] seg,
  output logic [3:0]       an,
  output logic             dp,
  output logic             frame_start
);

  localparam int TICKS  = SCAN_DIV / 16;
  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);

  if (SCAN_DIV < 16 || (SCAN_DIV % 16) != 0) begin : g_bad_div
    $error("SCAN_DIV must be a multiple of 16 and at least 16");
  end

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        sub_q, sub_d;
  logic [1:0]        dig_q, dig_d;
  logic              primed_q, primed_d;

  logic [3:0][7:0]   code_sh_q, code_sh_d;
  logic [3:0]        raw_sh_q, raw_sh_d;
  logic [3:0]        dpin_sh_q, dpin_sh_d;

  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [3:0]        an_q, an_d;
  logic              dp_q, dp_d;
  logic              fs_q, fs_d;

  logic              tick_wrap, sub_wrap, frame_bnd, load_sh, lit;
  logic [3:0][7:0]   in_codes, src_codes;
  logic [3:0]        src_raw, src_dp;
  logic [7:0]        sel_code;
  logic              sel_raw, sel_dp;
  logic [SEG_W-1:0]  dec_seg;
  logic              unused_code_msb;

  assign in_codes = {d3, d2, d1, d0};

  // Scan counters, frame boundary and shadow capture.
  always_comb begin
    tick_wrap = (tick_q == TICK_LAST);
    sub_wrap  = tick_wrap && (sub_q == SUB_LAST);
    frame_bnd = sub_wrap && (dig_q == DIG_LAST);

    tick_d   = tick_wrap ? '0 : tick_q + 1'b1;
    sub_d    = tick_wrap ? sub_q + 4'd1 : sub_q;
    dig_d    = sub_wrap ? dig_q + 2'd1 : dig_q;
    primed_d = primed_q | frame_bnd;
    fs_d     = frame_bnd;

    load_sh   = frame_bnd || !primed_q;
    code_sh_d = load_sh ? in_codes : code_sh_q;
    raw_sh_d  = load_sh ? raw      : raw_sh_q;
    dpin_sh_d = load_sh ? dp_in    : dpin_sh_q;
  end

  // Until the first frame boundary the shadow simply tracks the inputs, so the
  // live inputs are displayed directly rather than one cycle stale.
  always_comb begin
    src_codes = primed_q ? code_sh_q : in_codes;
    src_raw   = primed_q ? raw_sh_q  : raw;
    src_dp    = primed_q ? dpin_sh_q : dp_in;
    sel_code  = src_codes[dig_q];
    sel_raw   = src_raw[dig_q];
    sel_dp    = src_dp[dig_q];
  end

  assign unused_code_msb = sel_code[7];

  hex7_decode u_dec (
    .hex_i (sel_code[3:0]),
    .seg_o (dec_seg)
  );

  // Output stage: segments and dp forced dark whenever the anode is off.
  always_comb begin
    lit  = !blank && (sub_q <= duty);
    an_d  = 4'hF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (lit) begin
      an_d[dig_q] = 1'b0;
      seg_d       = sel_raw ? ~sel_code[SEG_W-1:0] : dec_seg;
      dp_d        = ~sel_dp;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      sub_q     <= '0;
      dig_q     <= '0;
      primed_q  <= 1'b0;
      code_sh_q <= '0;
      raw_sh_q  <= '0;
      dpin_sh_q <= '0;
      seg_q     <= SEG_OFF;
      an_q      <= 4'hF;
      dp_q      <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      sub_q     <= sub_d;
      dig_q     <= dig_d;
      primed_q  <= primed_d;
      code_sh_q <= code_sh_d;
      raw_sh_q  <= raw_sh_d;
      dpin_sh_q <= dpin_sh_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      fs_q      <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Directed bench for seg_scan4 with SCAN_DIV=16 (one clock per subphase).
module tb_seg_scan4;

  localparam int SCAN_DIV = 16;

  logic       clkin = 1'b0;
  logic       reset;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] raw, dp_in, duty;
  logic       blank;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  int new_from = 2;

  logic [6:0] glyph_old [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
  logic [6:0] glyph_new [4] = '{7'h09, 7'h24, 7'h08, 7'h19};
  logic       dp_new    [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  seg_scan4 #(.SCAN_DIV(SCAN_DIV)) dut (
    .clkin       (clkin),
    .reset       (reset),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .raw         (raw),
    .dp_in       (dp_in),
    .blank       (blank),
    .duty        (duty),
    .seg         (seg),
    .an          (an),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Advance one clock and check outputs against the counter state before it.
  task automatic step();
    int         s;
    logic [1:0] dig;
    logic [3:0] sub;
    logic       on, use_new;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    @(posedge clkin);
    k++;
    @(negedge clkin);
    s       = k - 1;
    dig     = 2'((s / 16) % 4);
    sub     = 4'(s % 16);
    use_new = ((s / 64) >= new_from);
    on      = !blank && (sub <= duty);
    an_e    = on ? ~(4'b0001 << dig) : 4'hF;
    seg_e   = !on ? 7'h7F : (use_new ? glyph_new[dig] : glyph_old[dig]);
    dp_e    = !on ? 1'b1 : (use_new ? dp_new[dig] : 1'b1);
    check("an", 32'(an), 32'(an_e));
    check("seg", 32'(seg), 32'(seg_e));
    check("dp", 32'(dp), 32'(dp_e));
    check("frame_start", 32'(frame_start), 32'((k % 64) == 0));
  endtask

  initial begin
    reset = 1'b1;
    d0 = 8'h01; d1 = 8'h02; d2 = 8'h03; d3 = 8'h04;
    raw = 4'b0000; dp_in = 4'b0000; duty = 4'd15; blank = 1'b0;
    repeat (2) @(negedge clkin);
    check("rst_an", 32'(an), 32'h0000_000F);
    check("rst_seg", 32'(seg), 32'h0000_007F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_fs", 32'(frame_start), 32'h0);

    reset = 1'b0;
    k = 0;
    new_from = 2;
    while (k < 360) begin
      step();
      if (k == 64) begin
        d0 = 8'h76; raw = 4'b0001; d2 = 8'h0A; dp_in = 4'b0100;
      end
      if (k == 192) duty = 4'd3;
      if (k == 256) blank = 1'b1;
      if (k == 320) begin
        blank = 1'b0; duty = 4'd15;
      end
    end

    // Mid digit 2: asynchronous reset must blank outputs before the next edge.
    check("pre_rst_an", 32'(an), 32'h0000_000B);
    #2 reset = 1'b1;
    #1;
    check("async_an", 32'(an), 32'h0000_000F);
    check("async_seg", 32'(seg), 32'h0000_007F);
    check("async_dp", 32'(dp), 32'h1);
    check("async_fs", 32'(frame_start), 32'h0);
    @(posedge clkin);
    @(negedge clkin);
    check("held_an", 32'(an), 32'h0000_000F);
    check("held_fs", 32'(frame_start), 32'h0);

    reset = 1'b0;
    k = 0;
    new_from = 0;
    repeat (64) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan4.md
SEG_SCAN4 -- requirements
Module: seg_scan4

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clkin cycles per digit slot; SHALL be a multiple of 16 and at least 16.
REQ-002 clkin  input  1  system clock, 100 MHz nominal.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 d0, d1, d2, d3  input  8 each  digit codes; d0 is the rightmost digit.
REQ-005 raw  input  4  per-digit mode: 1 = raw segment pattern, 0 = hex decode of the low nibble.
REQ-006 dp_in  input  4  per-digit decimal point, 1 = lit.
REQ-007 blank  input  1  1 = all anodes off.
REQ-008 duty  input  4  brightness level, 0..15.
REQ-009 seg  output  7  active-low segments; seg[0] = a through seg[6] = g.
REQ-010 an  output  4  active-low anodes; an[0] = digit 0.
REQ-011 dp  output  1  active-low decimal point.
REQ-012 frame_start  output  1  one-cycle pulse marking a shadow-register load.

Function
REQ-013 Counters SHALL be: tick (0..SCAN_DIV/16-1), subphase (0..15) and digit (0..3).
- tick increments every clkin cycle.
- subphase increments when tick wraps.
- digit increments, 3 wrapping to 0, when subphase wraps at 15.
REQ-014 The frame boundary SHALL be the cycle with digit=3, subphase=15 and tick=SCAN_DIV/16-1.
REQ-015 On the frame boundary, the shadow registers SHALL capture d0..d3, raw and dp_in, and frame_start SHALL be 1 on the following cycle only.
REQ-016 A primed flag SHALL be 0 from reset until the first frame boundary; while primed=0 the shadow registers SHALL load every cycle.
REQ-017 blank and duty SHALL be used unshadowed.
REQ-018 Segment source for the selected digit:
- raw=1: seg = ~d[6:0]; d[7] is ignored.
- raw=0: seg = hex decode of d[3:0], glyphs 0-9 and A, b, C, d, E, F; d[7:4] are ignored.
REQ-019 dp SHALL equal ~dp_in[digit] from the shadow registers.
REQ-020 an[digit] SHALL be 0 only when blank=0 and subphase <= duty.
- Every other anode bit SHALL be 1.
- duty=15 gives full on; duty=0 gives 1/16 on time.
REQ-021 While the active anode is off, seg SHALL be 7'h7F and dp SHALL be 1 (ghost suppression).
REQ-022 seg, an and dp SHALL be registered, with one clkin cycle of latency from the counter state.
REQ-023 All counter comparisons SHALL be on full counter width; the counters SHALL wrap without skipping values.
REQ-024 Input changes between frame boundaries SHALL NOT change displayed digits once primed=1.
REQ-025 Exactly one anode bit SHALL be 0 at any time, or none.

Reset
REQ-026 While reset=1, outputs SHALL be: an=4'hF, seg=7'h7F, dp=1, frame_start=0.
REQ-027 While reset=1, internal state SHALL be: tick=0, subphase=0, digit=0, primed=0, shadow registers=0.
REQ-028 Reset asserted mid-frame SHALL take effect immediately (asynchronous).
REQ-029 Counting SHALL resume from zero on the first clkin edge after reset deasserts.

Structure
REQ-030 A shared package SHALL hold:
- the 16-entry hex glyph table;
- segment bit-index constants;
- the default SCAN_DIV.
REQ-031 The combinational decoder SHALL be the sub-module hex7_decode (4-bit in, 7-bit active-low out).
REQ-032 The counters, shadow registers and output registers SHALL live in seg_scan4.

Verification (SCAN_DIV=16, so tick is always 0)
REQ-033 Reset, then d0..d3 = 1,2,3,4, raw=0, duty=15, blank=0 -> an cycles E,D,B,7 every 16 clk; seg = 79,24,30,19 hex respectively.
REQ-034 raw=4'b0001, d0=8'h76 -> during digit 0, seg=7'h09.
REQ-035 Change d2 mid-frame after the first frame_start -> display unchanged until the next frame_start; the new value is shown on digit 2 of the next frame.
REQ-036 duty=3 -> each anode is low 4 of 16 cycles; seg=7'h7F in the off cycles.
REQ-037 blank=1 -> an=4'hF every cycle; the counters keep running and frame_start still pulses every 64 cycles.
REQ-038 Assert reset during digit 2 -> an=F, seg=7F and dp=1 within the same cycle; after release, digit 0 is shown first and frame_start first pulses 64 cycles later.
